// File: rtl/pam4_defs.sv
// Shared PAM-4 definitions: checker FSM states plus level/threshold constants in
// half-SEP units, so the slicer and the level mapper use one consistent grid.
package pam4_defs;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } rx_state_e;

  // Levels sit at odd multiples of SEP/2, decision thresholds at the even ones.
  localparam int LEVEL_HALF_0    = -3;
  localparam int LEVEL_HALF_1    = -1;
  localparam int LEVEL_HALF_2    = 1;
  localparam int LEVEL_HALF_3    = 3;
  localparam int THRESH_HALF_LO  = -2;
  localparam int THRESH_HALF_MID = 0;
  localparam int THRESH_HALF_HI  = 2;

  function automatic int symbol_to_signal(input logic [1:0] sym, input int sep);
    int half;
    half = LEVEL_HALF_0;
    case (sym)
      2'd0: half = LEVEL_HALF_0;
      2'd1: half = LEVEL_HALF_1;
      2'd2: half = LEVEL_HALF_2;
      2'd3: half = LEVEL_HALF_3;
      default: half = LEVEL_HALF_0;
    endcase
    return (half * sep) / 2;
  endfunction

  function automatic logic [1:0] slice_sample(input int sample, input int sep);
    int twice;
    twice = 2 * sample;
    if (twice < THRESH_HALF_LO * sep) return 2'd0;
    else if (twice < THRESH_HALF_MID * sep) return 2'd1;
    else if (twice < THRESH_HALF_HI * sep) return 2'd2;
    else return 2'd3;
  endfunction

endpackage

// File: rtl/pam4_slicer.sv
// PAM-4 slicer: combinational threshold decision followed by the output register.
module pam4_slicer
  import pam4_defs::*;
#(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [SIGNAL_RESOLUTION-1:0] signal_in,
  input  logic                                signal_in_valid,
  output logic        [1:0]                   symbol_out,
  output logic                                symbol_out_valid
);

  logic [1:0] decision;

  always_comb begin
    decision = slice_sample(int'(signal_in), SYMBOL_SEPERATION);
  end

  // The decision holds across invalid cycles; only the valid flag drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      symbol_out       <= 2'd0;
      symbol_out_valid <= 1'b0;
    end else begin
      symbol_out_valid <= signal_in_valid;
      if (signal_in_valid) symbol_out <= decision;
    end
  end

endmodule

// File: rtl/pam4_rx_checker.sv
// PAM-4 receive checker: slices samples, aligns them to a reference history by
// searching the latency, then counts symbols and errors while locked.
module pam4_rx_checker
  import pam4_defs::*;
#(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 32,
  parameter int MAX_LATENCY       = 16,
  parameter int LOCK_WINDOW       = 32,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic signed [SIGNAL_RESOLUTION-1:0] signal_in,
  input  logic                                signal_in_valid,
  input  logic        [1:0]                   ref_symbol,
  input  logic                                ref_symbol_valid,
  input  logic                                clear_counts,
  output logic        [1:0]                   symbol_out,
  output logic                                symbol_out_valid,
  output logic                                locked,
  output logic        [$clog2(MAX_LATENCY)-1:0] latency,
  output logic        [CNT_WIDTH-1:0]         symbol_count,
  output logic        [CNT_WIDTH-1:0]         error_count
);

  localparam int LAT_W = $clog2(MAX_LATENCY);
  localparam int MC_W  = $clog2(LOCK_WINDOW + 1);
  localparam int WP_W  = $clog2(LOCK_WINDOW);

  rx_state_e             state, state_d;
  logic [1:0]            hist [MAX_LATENCY];
  logic [LAT_W-1:0]      latency_d, latency_inc;
  logic [MC_W-1:0]       match_cnt, match_cnt_d;
  logic [WP_W-1:0]       win_pos, win_pos_d;
  logic [MC_W-1:0]       win_err, win_err_d, err_sum;
  logic [CNT_WIDTH-1:0]  symbol_count_d, error_count_d;
  logic                  compare, mismatch;

  pam4_slicer #(
    .SIGNAL_RESOLUTION(SIGNAL_RESOLUTION),
    .SYMBOL_SEPERATION(SYMBOL_SEPERATION)
  ) u_slicer (
    .clk             (clk),
    .rst             (rstn),
    .signal_in       (signal_in),
    .signal_in_valid (signal_in_valid),
    .symbol_out      (symbol_out),
    .symbol_out_valid(symbol_out_valid)
  );

  // hist[0] is the newest reference symbol.
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int k = 0; k < MAX_LATENCY; k++) hist[k] <= 2'd0;
    end else if (ref_symbol_valid) begin
      for (int k = MAX_LATENCY - 1; k > 0; k--) hist[k] <= hist[k-1];
      hist[0] <= ref_symbol;
    end
  end

  // symbol_out and hist were both updated on the edge that took the sample, so a
  // reference delayed by D samples lines up with hist[D].
  always_comb begin
    compare     = symbol_out_valid;
    mismatch    = (symbol_out != hist[latency]);
    latency_inc = (latency == LAT_W'(MAX_LATENCY - 1)) ? '0 : latency + LAT_W'(1);
  end

  always_comb begin
    state_d        = state;
    latency_d      = latency;
    match_cnt_d    = match_cnt;
    win_pos_d      = win_pos;
    win_err_d      = win_err;
    symbol_count_d = symbol_count;
    error_count_d  = error_count;
    err_sum        = win_err + MC_W'(mismatch);
    case (state)
      SEARCH: begin
        if (compare) begin
          if (mismatch) begin
            match_cnt_d = '0;
            latency_d   = latency_inc;
          end else if (match_cnt == MC_W'(LOCK_WINDOW - 1)) begin
            state_d     = LOCKED;
            match_cnt_d = '0;
            win_pos_d   = '0;
            win_err_d   = '0;
          end else begin
            match_cnt_d = match_cnt + MC_W'(1);
          end
        end
      end
      LOCKED: begin
        if (compare) begin
          if (symbol_count != '1) symbol_count_d = symbol_count + CNT_WIDTH'(1);
          if (mismatch && (error_count != '1)) error_count_d = error_count + CNT_WIDTH'(1);
          if (err_sum > MC_W'(LOCK_WINDOW / 4)) begin
            state_d     = SEARCH;
            match_cnt_d = '0;
            latency_d   = latency_inc;
            win_pos_d   = '0;
            win_err_d   = '0;
          end else if (win_pos == WP_W'(LOCK_WINDOW - 1)) begin
            win_pos_d = '0;
            win_err_d = '0;
          end else begin
            win_pos_d = win_pos + WP_W'(1);
            win_err_d = err_sum;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
    if (clear_counts) begin
      symbol_count_d = '0;
      error_count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state        <= SEARCH;
      latency      <= '0;
      match_cnt    <= '0;
      win_pos      <= '0;
      win_err      <= '0;
      symbol_count <= '0;
      error_count  <= '0;
    end else begin
      state        <= state_d;
      latency      <= latency_d;
      match_cnt    <= match_cnt_d;
      win_pos      <= win_pos_d;
      win_err      <= win_err_d;
      symbol_count <= symbol_count_d;
      error_count  <= error_count_d;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_pam4_rx_checker.sv
// Self-checking bench for pam4_rx_checker: PRBS7 reference, delayed mapped channel,
// and a per-cycle behavioural model of slicing, alignment search and lock monitoring.
module tb_pam4_rx_checker;

  localparam int SEP   = 32;
  localparam int ML    = 16;
  localparam int LW    = 32;
  localparam int LAT_W = $clog2(ML);
  localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

  logic              clk;
  logic              rstn;
  logic signed [7:0] signal_in;
  logic              signal_in_valid;
  logic [1:0]        ref_symbol;
  logic              ref_symbol_valid;
  logic              clear_counts;
  logic [1:0]        symbol_out;
  logic              symbol_out_valid;
  logic              locked;
  logic [LAT_W-1:0]  latency;
  logic [31:0]       symbol_count;
  logic [31:0]       error_count;

  pam4_rx_checker #(
    .SIGNAL_RESOLUTION(8),
    .SYMBOL_SEPERATION(SEP),
    .MAX_LATENCY      (ML),
    .LOCK_WINDOW      (LW),
    .CNT_WIDTH        (32)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .signal_in       (signal_in),
    .signal_in_valid (signal_in_valid),
    .ref_symbol      (ref_symbol),
    .ref_symbol_valid(ref_symbol_valid),
    .clear_counts    (clear_counts),
    .symbol_out      (symbol_out),
    .symbol_out_valid(symbol_out_valid),
    .locked          (locked),
    .latency         (latency),
    .symbol_count    (symbol_count),
    .error_count     (error_count)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int diffs    = 0;
  logic [6:0] lfsr;
  logic [1:0] tx_q[$];

  // ---------------- reference model ----------------
  logic [1:0] m_sym;
  bit         m_sv;
  bit         m_locked;
  int         m_lat, m_run, m_wpos, m_werr;
  longint     m_scount, m_ecount;
  logic [1:0] m_hist[$];

  function automatic int level_of(input logic [1:0] s);
    int lv[4];
    lv = '{-3 * SEP / 2, -SEP / 2, SEP / 2, 3 * SEP / 2};
    return lv[s];
  endfunction

  // Decision = which SEP-wide bin the sample falls in, clamped to the 4 symbols.
  function automatic logic [1:0] model_slice(input int v);
    int q;
    q = v / SEP;
    if ((v % SEP != 0) && (v < 0)) q = q - 1;
    q = q + 2;
    if (q < 0) q = 0;
    if (q > 3) q = 3;
    return 2'(q);
  endfunction

  task automatic model_reset();
    m_sym = 2'd0; m_sv = 1'b0; m_locked = 1'b0;
    m_lat = 0; m_run = 0; m_wpos = 0; m_werr = 0;
    m_scount = 0; m_ecount = 0;
    m_hist.delete();
    for (int k = 0; k < ML; k++) m_hist.push_back(2'd0);
  endtask

  task automatic model_edge(input int sig, input bit sv, input logic [1:0] r, input bit rv,
                            input bit clr, input bit rst);
    bit miss;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_sv) begin
      miss = (m_sym != m_hist[m_lat]);
      if (!m_locked) begin
        if (miss) begin
          m_run = 0;
          m_lat = (m_lat + 1) % ML;
        end else begin
          m_run++;
          if (m_run == LW) begin
            m_locked = 1'b1; m_run = 0; m_wpos = 0; m_werr = 0;
          end
        end
      end else begin
        if (m_scount < CNT_MAX) m_scount++;
        if (miss) begin
          if (m_ecount < CNT_MAX) m_ecount++;
          m_werr++;
        end
        if (m_werr > LW / 4) begin
          m_locked = 1'b0; m_run = 0; m_lat = (m_lat + 1) % ML; m_wpos = 0; m_werr = 0;
        end else begin
          m_wpos++;
          if (m_wpos == LW) begin
            m_wpos = 0; m_werr = 0;
          end
        end
      end
    end
    if (clr) begin
      m_scount = 0; m_ecount = 0;
    end
    if (sv) m_sym = model_slice(sig);
    m_sv = sv;
    if (rv) begin
      m_hist.push_front(r);
      void'(m_hist.pop_back());
    end
  endtask

  function automatic bit model_diff();
    return (symbol_out !== m_sym) || (symbol_out_valid !== m_sv) || (locked !== m_locked) ||
           (latency !== LAT_W'(m_lat)) || (symbol_count !== 32'(m_scount)) ||
           (error_count !== 32'(m_ecount));
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input int sig, input bit sv, input logic [1:0] r, input bit rv,
                       input bit clr, input bit rst);
    signal_in        = 8'(sig);
    signal_in_valid  = sv;
    ref_symbol       = r;
    ref_symbol_valid = rv;
    clear_counts     = clr;
    rstn             = rst;
    @(posedge clk);
    model_edge(sig, sv, r, rv, clr, rst);
    #1;
    if (model_diff()) diffs++;
  endtask

  task automatic prbs_sym(output logic [1:0] s);
    logic b;
    for (int i = 0; i < 2; i++) begin
      b = lfsr[6] ^ lfsr[5];
      lfsr = {lfsr[5:0], b};
      s[i] = b;
    end
  endtask

  // Produces the next reference symbol and the one transmitted d symbols earlier.
  task automatic next_ref(input int d, output logic [1:0] r, output logic [1:0] s);
    prbs_sym(r);
    tx_q.push_front(r);
    void'(tx_q.pop_back());
    s = tx_q[d];
  endtask

  task automatic clean_step(input int d);
    logic [1:0] r, s;
    next_ref(d, r, s);
    drive(level_of(s), 1'b1, r, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1);
    drive(0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (symbol_out !== 2'd0) begin n_fail++; $display("FAIL reset_symbol_out: got %0d, required 0", symbol_out); end
    n_checks++; if (symbol_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b, required 0", symbol_out_valid); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b, required 0", locked); end
    n_checks++; if (latency !== '0) begin n_fail++; $display("FAIL reset_latency: got %0d, required 0", latency); end
    n_checks++; if (symbol_count !== 32'd0) begin n_fail++; $display("FAIL reset_symbol_count: got %0d, required 0", symbol_count); end
    n_checks++; if (error_count !== 32'd0) begin n_fail++; $display("FAIL reset_error_count: got %0d, required 0", error_count); end
  endtask

  task automatic test_prbs_lock();
    int d0;
    do_reset();
    d0 = diffs;
    for (int i = 0; i < 2000; i++) clean_step(3);
    n_checks++; if (diffs - d0 !== 0) begin n_fail++; $display("FAIL prbs_track: %0d cycles differed from model, required 0", diffs - d0); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL prbs_locked: got %0b, required 1", locked); end
    n_checks++; if (latency !== LAT_W'(3)) begin n_fail++; $display("FAIL prbs_latency: got %0d, required 3", latency); end
    n_checks++; if (error_count !== 32'd0) begin n_fail++; $display("FAIL prbs_errors: got %0d, required 0", error_count); end
    n_checks++; if (symbol_count !== 32'(m_scount)) begin n_fail++; $display("FAIL prbs_symbols: got %0d, required %0d", symbol_count, m_scount); end
  endtask

  task automatic test_slicer_boundaries();
    logic [1:0] r, s;
    int sig, d0;
    int bnd[4];
    bnd = '{-SEP - 1, -SEP, SEP - 1, SEP};
    d0 = diffs;
    next_ref(3, r, s);
    drive(level_of(s), 1'b1, r, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      next_ref(3, r, s);
      sig = bnd[s];
      drive(sig, 1'b1, r, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (symbol_out !== s) begin
        n_fail++; $display("FAIL slicer_boundary: signal %0d gave %0d, required %0d", sig, symbol_out, s);
      end
    end
    next_ref(3, r, s);
    drive(level_of(s ^ 2'd2), 1'b1, r, 1'b1, 1'b0, 1'b0);
    clean_step(3);
    n_checks++; if (error_count !== 32'd1) begin n_fail++; $display("FAIL single_flip_errors: got %0d, required 1", error_count); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL single_flip_locked: got %0b, required 1", locked); end
    n_checks++; if (diffs - d0 !== 0) begin n_fail++; $display("FAIL boundary_track: %0d cycles differed from model, required 0", diffs - d0); end
  endtask

  task automatic test_latency_edges();
    logic [ML-1:0] seen;
    bit any_lock, saw_wrap;
    logic [LAT_W-1:0] prev;
    int d0;
    do_reset();
    d0 = diffs;
    seen = '0;
    for (int i = 0; i < 1500; i++) begin
      clean_step(ML - 1);
      if (locked !== 1'b1) seen[latency] = 1'b1;
    end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL d15_locked: got %0b, required 1", locked); end
    n_checks++; if (latency !== LAT_W'(ML - 1)) begin n_fail++; $display("FAIL d15_latency: got %0d, required %0d", latency, ML - 1); end
    n_checks++; if (seen !== '1) begin n_fail++; $display("FAIL d15_walk: latencies visited %h, required %h", seen, {ML{1'b1}}); end
    do_reset();
    any_lock = 1'b0; saw_wrap = 1'b0; prev = latency;
    for (int i = 0; i < 1500; i++) begin
      clean_step(ML);
      if (locked !== 1'b0) any_lock = 1'b1;
      if (prev == LAT_W'(ML - 1) && latency == '0) saw_wrap = 1'b1;
      prev = latency;
    end
    n_checks++; if (any_lock !== 1'b0) begin n_fail++; $display("FAIL d16_never_lock: locked seen %0b, required 0", any_lock); end
    n_checks++; if (saw_wrap !== 1'b1) begin n_fail++; $display("FAIL d16_wrap: wrap seen %0b, required 1", saw_wrap); end
    n_checks++; if (diffs - d0 !== 0) begin n_fail++; $display("FAIL latency_track: %0d cycles differed from model, required 0", diffs - d0); end
  endtask

  task automatic test_error_burst();
    logic [1:0] r, s;
    bit corrupt[41];
    int pos[$];
    int j9, drop_at, d0;
    longint sc0, ec0;
    do_reset();
    d0 = diffs;
    for (int i = 0; i < 2000 && !m_locked; i++) clean_step(3);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL burst_prelock: got %0b, required 1", locked); end
    sc0 = m_scount; ec0 = m_ecount;
    for (int j = 0; j < 41; j++) corrupt[j] = 1'b0;
    for (int j = 1; j < LW; j++) pos.push_back(j);
    pos.shuffle();
    j9 = 0;
    for (int k = 0; k < 9; k++) begin
      corrupt[pos[k]] = 1'b1;
      if (pos[k] > j9) j9 = pos[k];
    end
    drop_at = -1;
    for (int j = 1; j <= 40; j++) begin
      next_ref(3, r, s);
      drive(corrupt[j] ? level_of(s ^ 2'd2) : level_of(s), 1'b1, r, 1'b1, 1'b0, 1'b0);
      if (drop_at < 0 && locked === 1'b0) drop_at = j;
      if (j == j9 + 1) begin
        n_checks++; if (error_count !== 32'(ec0 + 9)) begin n_fail++; $display("FAIL burst_errors: got %0d, required %0d", error_count, ec0 + 9); end
        n_checks++; if (symbol_count !== 32'(sc0 + j9 + 1)) begin n_fail++; $display("FAIL burst_symbols: got %0d, required %0d", symbol_count, sc0 + j9 + 1); end
      end
    end
    n_checks++; if (drop_at !== j9 + 1) begin n_fail++; $display("FAIL burst_drop_cycle: got %0d, required %0d", drop_at, j9 + 1); end
    n_checks++; if (error_count !== 32'(ec0 + 9)) begin n_fail++; $display("FAIL burst_errors_hold: got %0d, required %0d", error_count, ec0 + 9); end
    n_checks++; if (symbol_count !== 32'(sc0 + j9 + 1)) begin n_fail++; $display("FAIL burst_symbols_hold: got %0d, required %0d", symbol_count, sc0 + j9 + 1); end
    for (int i = 0; i < 1500; i++) clean_step(3);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock: got %0b, required 1", locked); end
    n_checks++; if (latency !== LAT_W'(3)) begin n_fail++; $display("FAIL relock_latency: got %0d, required 3", latency); end
    n_checks++; if (diffs - d0 !== 0) begin n_fail++; $display("FAIL burst_track: %0d cycles differed from model, required 0", diffs - d0); end
  endtask

  task automatic test_clear_counts();
    logic [1:0] r, s;
    for (int i = 0; i < 40; i++) clean_step(3);
    next_ref(3, r, s);
    drive(level_of(s ^ 2'd2), 1'b1, r, 1'b1, 1'b0, 1'b0);
    next_ref(3, r, s);
    drive(level_of(s), 1'b1, r, 1'b1, 1'b1, 1'b0);
    n_checks++; if (symbol_count !== 32'd0) begin n_fail++; $display("FAIL clear_symbols: got %0d, required 0", symbol_count); end
    n_checks++; if (error_count !== 32'd0) begin n_fail++; $display("FAIL clear_errors: got %0d, required 0", error_count); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL clear_locked: got %0b, required 1", locked); end
    n_checks++; if (latency !== LAT_W'(3)) begin n_fail++; $display("FAIL clear_latency: got %0d, required 3", latency); end
    clean_step(3);
    n_checks++; if (symbol_count !== 32'd1) begin n_fail++; $display("FAIL post_clear_symbols: got %0d, required 1", symbol_count); end
    n_checks++; if (error_count !== 32'd0) begin n_fail++; $display("FAIL post_clear_errors: got %0d, required 0", error_count); end
  endtask

  task automatic test_reset_midlock();
    logic [1:0] r, s;
    int d0;
    d0 = diffs;
    next_ref(3, r, s);
    drive(level_of(s), 1'b1, r, 1'b1, 1'b0, 1'b1);
    n_checks++; if (symbol_out !== 2'd0) begin n_fail++; $display("FAIL midrst_symbol_out: got %0d, required 0", symbol_out); end
    n_checks++; if (symbol_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b, required 0", symbol_out_valid); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL midrst_locked: got %0b, required 0", locked); end
    n_checks++; if (latency !== '0) begin n_fail++; $display("FAIL midrst_latency: got %0d, required 0", latency); end
    n_checks++; if (symbol_count !== 32'd0) begin n_fail++; $display("FAIL midrst_symbols: got %0d, required 0", symbol_count); end
    n_checks++; if (error_count !== 32'd0) begin n_fail++; $display("FAIL midrst_errors: got %0d, required 0", error_count); end
    for (int i = 0; i < 1500; i++) clean_step(3);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL midrst_relock: got %0b, required 1", locked); end
    n_checks++; if (latency !== LAT_W'(3)) begin n_fail++; $display("FAIL midrst_relock_latency: got %0d, required 3", latency); end
    n_checks++; if (diffs - d0 !== 0) begin n_fail++; $display("FAIL midrst_track: %0d cycles differed from model, required 0", diffs - d0); end
  endtask

  task automatic test_independent_valids();
    int d0, sig;
    logic [1:0] r;
    bit sv, rv, clr;
    do_reset();
    d0 = diffs;
    for (int i = 0; i < 600; i++) begin
      sig = int'($urandom_range(0, 255)) - 128;
      r   = 2'($urandom_range(0, 3));
      sv  = 1'($urandom_range(0, 1));
      rv  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 49) == 0);
      drive(sig, sv, r, rv, clr, 1'b0);
    end
    n_checks++; if (diffs - d0 !== 0) begin n_fail++; $display("FAIL independent_track: %0d cycles differed from model, required 0", diffs - d0); end
    n_checks++; if (symbol_out_valid !== m_sv) begin n_fail++; $display("FAIL independent_valid: got %0b, required %0b", symbol_out_valid, m_sv); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rstn             = 1'b1;
    signal_in        = '0;
    signal_in_valid  = 1'b0;
    ref_symbol       = 2'd0;
    ref_symbol_valid = 1'b0;
    clear_counts     = 1'b0;
    lfsr             = 7'($urandom_range(1, 127));
    for (int k = 0; k < 40; k++) tx_q.push_back(2'd0);
    model_reset();

    test_reset();
    test_prbs_lock();
    test_slicer_boundaries();
    test_latency_edges();
    test_error_burst();
    test_clear_counts();
    test_reset_midlock();
    test_independent_valids();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
